// File: rtl/spart_pkg.sv
// spart_pkg -- shared types and defaults for the SPART receiver.
//   state_t        : receiver FSM state encoding
//   DATA_BITS_DEF  : default data bits per frame
//   OVERSAMPLE_DEF : default rx_enable ticks per bit
package spart_pkg;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

endpackage

// File: rtl/spart_sync2.sv
// spart_sync2 -- two-flop synchronizer for an asynchronous level input.
// Both flops reset to 1 so a serial line reads as idle straight out of reset.
//   clk : system clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output
module spart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// spart_rx -- oversampling UART-style serial receiver.
// Optional feature: define SPART_RX_PARITY_EN to expect one even-parity bit
// after the data bits; otherwise parity_err is tied to 0.
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   rx_enable   : one-cycle tick at OVERSAMPLE x baud
//   rxd         : asynchronous serial line, idle high
//   rd_ack      : host consumed rx_data, clears rda and overrun_err
//   rx_data     : last received word
//   rda         : receive data available
//   frame_err   : stop bit of last frame sampled low
//   overrun_err : sticky, a frame completed while rda was still set
//   parity_err  : parity mismatch on last frame
module spart_rx
    import spart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    state_t               state;
    logic [CNT_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_wait;  // stop bit was low; waiting for the line to recover

`ifdef SPART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    spart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            stop_wait   <= 1'b0;
            rx_data     <= '0;
            rda         <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            par_bit     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            // Host acknowledge; a completing frame below overrides these.
            if (rd_ack && rda) begin
                rda         <= 1'b0;
                overrun_err <= 1'b0;
            end

            if (rx_enable) begin
                unique case (state)
                    StIdle: begin
                        if (!rxd_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                        end
                    end

                    StStart: begin
                        if (tick_cnt == CNT_MID) begin
                            if (rxd_s) begin
                                state <= StIdle;  // glitch, not a start bit
                            end else begin
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                                state    <= StData;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    StData: begin
                        if (tick_cnt == CNT_FULL) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == IDX_LAST) begin
`ifdef SPART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef SPART_RX_PARITY_EN
                    StParity: begin
                        if (tick_cnt == CNT_FULL) begin
                            tick_cnt <= '0;
                            par_bit  <= rxd_s;
                            state    <= StStop;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif

                    StStop: begin
                        if (stop_wait) begin
                            // Break: no counting, so a held-low line cannot
                            // produce further frames.
                            if (rxd_s) begin
                                stop_wait <= 1'b0;
                                state     <= StIdle;
                            end
                        end else if (tick_cnt == CNT_FULL) begin
                            tick_cnt  <= '0;
                            rx_data   <= shift_reg;
                            frame_err <= ~rxd_s;
`ifdef SPART_RX_PARITY_EN
                            par_err_q <= ^{shift_reg, par_bit};
`endif
                            rda       <= 1'b1;
                            // Completion wins over a same-cycle rd_ack.
                            if (rda && !rd_ack) begin
                                overrun_err <= 1'b1;
                            end else begin
                                overrun_err <= overrun_err;
                            end
                            if (rxd_s) begin
                                state <= StIdle;
                            end else begin
                                stop_wait <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx -- directed, scoreboard-based bench for spart_rx.
module tb_spart_rx;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK     = 4;
    localparam int BIT_CLKS = OS * TICK;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_enable;
    logic          rxd;
    logic          rd_ack;
    logic [DB-1:0] rx_data;
    logic          rda;
    logic          frame_err;
    logic          overrun_err;
    logic          parity_err;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          rise_cnt = 0;
    int unsigned rise_cyc = 0;
    logic        rise_prev_en = 1'b0;
    logic        rda_d = 1'b0;
    logic        en_d = 1'b0;
    int unsigned t0;
    int unsigned offset;
    int          r0;

    spart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_enable   (rx_enable),
        .rxd         (rxd),
        .rd_ack      (rd_ack),
        .rx_data     (rx_data),
        .rda         (rda),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one cycle in every TICK.
    initial begin
        rx_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1 rx_enable = ((cyc % TICK) == 0);
        end
    end

    // Record every rising edge of rda and whether the preceding cycle was a tick.
    always @(negedge clk) begin
        if (rda === 1'b1 && rda_d !== 1'b1) begin
            rise_cnt++;
            rise_cyc     = cyc;
            rise_prev_en = en_d;
        end
        rda_d = rda;
        en_d  = rx_enable;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % TICK) != 0);
    endtask

    task automatic drive(input logic v, input int nclk);
        rxd = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] data, input logic par_flip);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < DB; i++) drive(data[i], BIT_CLKS);
`ifdef SPART_RX_PARITY_EN
        drive((^data) ^ par_flip, BIT_CLKS);
`else
        if (par_flip) $display("note: parity disabled, flip ignored");
`endif
    endtask

    function automatic logic exp_perr(input logic par_flip);
`ifdef SPART_RX_PARITY_EN
        return par_flip;
`else
        if (par_flip) return 1'b0;
        return 1'b0;
`endif
    endfunction

    task automatic send_frame(input logic [7:0] data, input logic par_flip);
        exp_q.push_back('{data: data, ferr: 1'b0, perr: exp_perr(par_flip)});
        send_body(data, par_flip);
        drive(1'b1, BIT_CLKS);
        drive(1'b1, 8);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rx_data"}, 32'(rx_data), 32'(e.data));
            chk({tag, "_frame_err"}, 32'(frame_err), 32'(e.ferr));
            chk({tag, "_parity_err"}, 32'(parity_err), 32'(e.perr));
        end
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        rxd    = 1'b1;
        rd_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_rda", 32'(rda), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun_err), 32'd0);
        chk("rst_parity", 32'(parity_err), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Basic frame, also measures start-to-completion offset.
        align();
        t0 = cyc;
        r0 = rise_cnt;
        send_frame(8'hA5, 1'b0);
        chk("a5_rise_count", 32'(rise_cnt - r0), 32'd1);
        chk("a5_latency_after_tick", 32'(rise_prev_en), 32'd1);
        offset = rise_cyc - t0;
        check_frame("a5");
        chk("a5_rda", 32'(rda), 32'd1);
        ack_pulse();
        chk("a5_ack_rda", 32'(rda), 32'd0);
        chk("a5_ack_overrun", 32'(overrun_err), 32'd0);

        // False start: low for 5 ticks only.
        align();
        r0 = rise_cnt;
        drive(1'b0, 5 * TICK);
        drive(1'b1, 40 * TICK);
        chk("false_start_rise", 32'(rise_cnt - r0), 32'd0);
        chk("false_start_rda", 32'(rda), 32'd0);

        // Receiver must be back in idle and decode normally.
        align();
        send_frame(8'h5A, 1'b0);
        check_frame("after_false");
        ack_pulse();

        // Break: stop bit low, line held low 40 ticks, then high.
        align();
        r0 = rise_cnt;
        exp_q.push_back('{data: 8'h3C, ferr: 1'b1, perr: 1'b0});
        send_body(8'h3C, 1'b0);
        drive(1'b0, 20 * TICK);
        check_frame("break");
        ack_pulse();
        drive(1'b0, 20 * TICK);
        drive(1'b1, 2 * BIT_CLKS);
        chk("break_single_rda", 32'(rise_cnt - r0), 32'd1);
        chk("break_rda_cleared", 32'(rda), 32'd0);

        align();
        send_frame(8'hC3, 1'b0);
        check_frame("after_break");
        ack_pulse();

        // Overrun.
        align();
        send_frame(8'h11, 1'b0);
        check_frame("ovr_first");
        chk("ovr_first_flag", 32'(overrun_err), 32'd0);
        align();
        send_frame(8'h22, 1'b0);
        check_frame("ovr_second");
        chk("ovr_flag", 32'(overrun_err), 32'd1);
        chk("ovr_rda", 32'(rda), 32'd1);
        ack_pulse();
        chk("ovr_ack_rda", 32'(rda), 32'd0);
        chk("ovr_ack_flag", 32'(overrun_err), 32'd0);

        // rd_ack in the completion cycle of a second frame.
        align();
        send_frame(8'h96, 1'b0);
        check_frame("coll_first");
        align();
        fork
            send_frame(8'h69, 1'b0);
            begin
                repeat (offset - 1) @(posedge clk);
                #1 rd_ack = 1'b1;
                @(posedge clk);
                #1 rd_ack = 1'b0;
            end
        join
        check_frame("coll_second");
        chk("coll_rda", 32'(rda), 32'd1);
        chk("coll_overrun", 32'(overrun_err), 32'd0);
        ack_pulse();

`ifdef SPART_RX_PARITY_EN
        align();
        send_frame(8'h07, 1'b1);
        check_frame("parity_bad");
        ack_pulse();
`endif

        // Reset in the middle of the data bits.
        align();
        r0 = rise_cnt;
        drive(1'b0, BIT_CLKS);
        drive(1'b1, BIT_CLKS);
        drive(1'b0, BIT_CLKS / 2);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_rda", 32'(rda), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_overrun", 32'(overrun_err), 32'd0);
        chk("midrst_parity", 32'(parity_err), 32'd0);
        rst = 1'b0;
        drive(1'b1, 10 * BIT_CLKS);
        chk("midrst_no_rise", 32'(rise_cnt - r0), 32'd0);
        chk("midrst_rda_idle", 32'(rda), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, rx_enable ticks per bit.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port rx_enable, input, 1, single-cycle pulse from the baud generator at OVERSAMPLE x baud.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rd_ack, input, 1, host has consumed rx_data; clears rda.
REQ-008 SHALL have port rx_data, output, DATA_BITS, last received byte.
REQ-009 SHALL have port rda, output, 1, receive data available.
REQ-010 SHALL have port frame_err, output, 1, stop bit of last frame sampled low.
REQ-011 SHALL have port overrun_err, output, 1, sticky; a frame completed while rda was 1.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch on last frame.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all sampling uses the synchronized rxd_s.
REQ-014 SHALL advance the tick counter and the FSM only in cycles where rx_enable=1.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on a tick with rxd_s=0, SHALL go to START and clear the tick count.
REQ-017 START: on tick count OVERSAMPLE/2-1 (mid-bit), if rxd_s=1 SHALL return to IDLE (false start); otherwise SHALL clear the count, clear bit_idx and go to DATA.
REQ-018 DATA: every OVERSAMPLE ticks SHALL sample rxd_s into the shift register LSB-first.
REQ-019 DATA: after DATA_BITS samples SHALL go to PARITY if the macro is defined, else to STOP.
REQ-020 PARITY: after OVERSAMPLE ticks SHALL sample the parity bit and go to STOP.
REQ-021 STOP: after OVERSAMPLE ticks SHALL sample the stop bit.
REQ-022 At the stop-bit sample SHALL load rx_data, set frame_err=~rxd_s, and set parity_err.
REQ-023 rda SHALL rise in the clock cycle after the stop-bit sample tick (latency 1 clk).
REQ-024 If the stop bit is 1, SHALL return to IDLE.
REQ-025 If the stop bit is 0, SHALL stay in STOP (no counting) until a tick sees rxd_s=1, then go to IDLE; a break never produces repeated frames.
REQ-026 rd_ack SHALL clear rda and overrun_err the next cycle; frame_err and parity_err hold until the next frame completes.
REQ-027 If rd_ack and frame completion occur in the same cycle, completion SHALL win: rda=1 and overrun_err unchanged.
REQ-028 If a frame completes with rda=1 and no rd_ack, SHALL overwrite rx_data and set overrun_err=1.
REQ-029 SHALL ignore rd_ack when rda=0.

Reset
REQ-030 With rst=1 at a clock edge, SHALL set FSM=IDLE, counters=0, shift register=0, rx_data=0, rda=0, and all error flags=0.
REQ-031 SHALL treat synchronizer flops as reset to 1 (line idle).
REQ-032 Reset mid-frame SHALL abort the frame with no rda pulse.

Configuration
REQ-033 Macro SPART_RX_PARITY_EN: when defined, SHALL expect one even-parity bit after the data bits; parity_err=1 if the XOR of data and parity bits is 1.
REQ-034 Without SPART_RX_PARITY_EN, SHALL omit the PARITY state and tie parity_err to 0; the port list is unchanged.

Structure
REQ-035 Package spart_pkg SHALL hold the FSM state typedef and default constants DATA_BITS_DEF=8 and OVERSAMPLE_DEF=16.
REQ-036 SHALL instantiate one sub-module, spart_sync2 (2-flop synchronizer, reset value 1); the rest stays flat.

Verification
REQ-037 Tick every 4 clk; send 0xA5, stop=1 -> rx_data=0xA5, rda=1 one clk after stop sample, frame_err=0.
REQ-038 Drive rxd low for 5 ticks, then high -> FSM returns to IDLE and rda stays 0.
REQ-039 Send 0x3C with stop=0, line held low for 40 ticks, then high -> exactly one rda, rx_data=0x3C, frame_err=1, then IDLE.
REQ-040 Send 0x11 then 0x22 with no rd_ack -> rx_data=0x22, overrun_err=1; rd_ack -> rda=0, overrun_err=0.
REQ-041 Assert rd_ack in the completion cycle of a second byte -> rda stays 1.
REQ-042 With SPART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1; apply rst mid-DATA -> all outputs 0, no rda.
